gpu_host_link: RTL and testbench

//  Host-side initiator for the GPU card command interface (cpu_recv_instr/cpu_in_data/cpu_out_data/cpu_out_ack).

---
 rtl/gpu_host_link.sv | 143 ++++++++++++++
 tb/tb_gpu_host_link.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_host_link.sv
// Host-side initiator for the GPU card word-level command interface.
// Serialises one copy/launch request at a time into CMD, LEN and data beats, with ack timeout.
module gpu_host_link #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [31:0]            req_addr,
  input  logic [COUNT_WIDTH-1:0] req_count,
  input  logic                   wr_valid,
  input  logic [31:0]            wr_data,
  output logic                   wr_ready,
  output logic                   rd_valid,
  output logic [31:0]            rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            cpu_recv_instr,
  output logic [31:0]            cpu_in_data,
  input  logic [31:0]            cpu_out_data,
  input  logic                   cpu_out_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_XFER,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] OP_TO_GPU   = 2'd1;
  localparam logic [1:0] OP_FROM_GPU = 2'd2;
  localparam logic [1:0] OP_KERNEL   = 2'd3;

  state_t                 state_q, state_d;
  logic [1:0]             op_q;
  logic [31:0]            addr_q;
  logic [COUNT_WIDTH-1:0] rem_q;
  logic [31:0]            tcnt_q;
  logic [31:0]            last_q;
  logic                   xfer_live;
  logic                   ack_take;
  logic                   tout_hit;

  assign tout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    busy           = 1'b1;
    wr_ready       = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    cpu_recv_instr = '0;
    cpu_in_data    = '0;
    xfer_live      = 1'b0;
    ack_take       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) state_d = (req_op == 2'd0) ? S_ERR : S_CMD;
      end
      S_CMD: begin
        cpu_recv_instr = {30'b0, op_q};
        cpu_in_data    = addr_q;
        state_d        = S_LEN;
      end
      S_LEN: begin
        cpu_in_data = (op_q == OP_KERNEL) ? '0 : 32'(rem_q);
        if (op_q != OP_KERNEL && rem_q == '0) state_d = S_DONE;
        else                                   state_d = S_XFER;
      end
      S_XFER: begin
        // A write copy only progresses (acks and timeout) while the host offers a word
        xfer_live = (op_q != OP_TO_GPU) || wr_valid;
        ack_take  = xfer_live && cpu_out_ack;
        if (op_q == OP_TO_GPU) begin
          cpu_in_data = wr_valid ? wr_data : last_q;
          wr_ready    = ack_take;
        end
        if (ack_take) begin
          if (op_q == OP_KERNEL || rem_q == COUNT_WIDTH'(1)) state_d = S_DONE;
        end else if (xfer_live && tout_hit) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      tcnt_q   <= '0;
      last_q   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      last_q   <= cpu_in_data;
      if (state_q == S_IDLE && req_valid) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        rem_q  <= req_count;
      end
      if (state_q != S_XFER) begin
        tcnt_q <= '0;
      end else if (ack_take) begin
        tcnt_q <= '0;
        rem_q  <= rem_q - COUNT_WIDTH'(1);
        if (op_q == OP_FROM_GPU) begin
          rd_data  <= cpu_out_data;
          rd_valid <= 1'b1;
        end
      end else if (xfer_live) begin
        tcnt_q <= tcnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_gpu_host_link.sv
// Bench for gpu_host_link: table of directed requests, hand-written reset sequence,
// and randomized requests whose latencies and data streams are derived from the protocol rules.
module tb_gpu_host_link;
  localparam int unsigned TO = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_count = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] cpu_recv_instr;
  logic [31:0] cpu_in_data;
  logic [31:0] cpu_out_data = '0;
  logic        cpu_out_ack = 1'b0;

  always #5 clk = ~clk;

  gpu_host_link #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_count(req_count),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .cpu_recv_instr(cpu_recv_instr), .cpu_in_data(cpu_in_data),
    .cpu_out_data(cpu_out_data), .cpu_out_ack(cpu_out_ack)
  );

  typedef struct {
    int          op;
    logic [31:0] addr;
    int          count;
    int          gap;
    int          dly;
    int          noisy;
    int          no_ack;
    logic [31:0] base;
    int          e_done;
    int          e_err;
    int          e_instr;
    int          e_len;
    int          e_wr;
    int          e_rd;
    int          e_rel;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int txn_id = 0;

  // Per-request observations, cleared by the monitor whenever txn_id advances
  int seen_id = 0;
  int done_cnt, err_cnt, done_cyc, err_cyc, busy_cnt, rdy_bad;
  int instr_cnt, instr_cyc;
  logic [31:0] instr_val, cmd_data, len_data;
  bit len_next;
  logic [31:0] got_wr[$];
  logic [31:0] got_rd[$];

  logic [31:0] wdat[64];
  int gap[64];
  int dly[64];
  int acc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (seen_id != txn_id) begin
      seen_id = txn_id;
      done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
      busy_cnt = 0; rdy_bad = 0; instr_cnt = 0; instr_cyc = -1;
      instr_val = '0; cmd_data = '0; len_data = '0; len_next = 1'b0;
      got_wr.delete();
      got_rd.delete();
    end
    if (rst) begin
      if (wr_ready) got_wr.push_back(cpu_in_data);
      if (rd_valid) got_rd.push_back(rd_data);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (busy) busy_cnt++;
      if (busy == req_ready) rdy_bad++;
      if (len_next) begin len_data = cpu_in_data; len_next = 1'b0; end
      if (cpu_recv_instr != 0) begin
        instr_cnt++; instr_val = cpu_recv_instr; cmd_data = cpu_in_data;
        instr_cyc = cyc; len_next = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input vec_t v);
    int n;
    int lim;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    txn_id++;
    acc = cyc;
    req_valid = 1'b1; req_op = 2'(v.op); req_addr = v.addr; req_count = 16'(v.count);
    tick();
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = $urandom; req_count = 16'($urandom);
    for (int k = 0; k < 2; k++) begin
      cpu_out_ack  = (v.noisy != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      cpu_out_data = $urandom;
      tick();
    end
    cpu_out_ack = 1'b0;
    if (v.no_ack == 0 && v.op != 0) begin
      if (v.op == 3) begin
        repeat (dly[0]) tick();
        cpu_out_ack = 1'b1; cpu_out_data = $urandom;
        tick();
        cpu_out_ack = 1'b0;
      end else begin
        for (int i = 0; i < v.count; i++) begin
          if (v.op == 1) begin
            wr_valid = 1'b0;
            for (int g = 0; g < gap[i]; g++) begin
              cpu_out_ack = (v.noisy != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
              tick();
            end
            cpu_out_ack = 1'b0;
            wr_valid = 1'b1; wr_data = wdat[i];
            repeat (dly[i]) tick();
            cpu_out_ack = 1'b1;
            tick();
            cpu_out_ack = 1'b0;
          end else begin
            repeat (dly[i]) tick();
            cpu_out_ack = 1'b1; cpu_out_data = wdat[i];
            tick();
            cpu_out_ack = 1'b0; cpu_out_data = $urandom;
          end
        end
        wr_valid = 1'b0;
      end
    end
    lim = 0;
    while (done_cnt == 0 && err_cnt == 0 && lim < 400) begin tick(); lim++; end
    repeat (2) tick();

    chk("finished", 64'(done_cnt + err_cnt > 0), 64'd1);
    chk("done_count", 64'(done_cnt), 64'(v.e_done));
    chk("err_count", 64'(err_cnt), 64'(v.e_err));
    chk("end_cycle", 64'((v.e_done != 0) ? done_cyc : err_cyc), 64'(acc + v.e_rel));
    chk("busy_cycles", 64'(busy_cnt), 64'(v.e_rel));
    chk("ready_vs_busy", 64'(rdy_bad), 64'd0);
    chk("instr_count", 64'(instr_cnt), 64'(v.e_instr));
    if (v.e_instr != 0) begin
      chk("instr_value", 64'(instr_val), 64'(v.op));
      chk("instr_cycle", 64'(instr_cyc), 64'(acc + 1));
      chk("cmd_data", 64'(cmd_data), 64'(v.addr));
      chk("len_data", 64'(len_data), 64'(v.e_len));
    end
    chk("wr_beats", 64'(got_wr.size()), 64'(v.e_wr));
    chk("rd_beats", 64'(got_rd.size()), 64'(v.e_rd));
    for (int i = 0; i < v.e_wr && i < got_wr.size(); i++) chk("wr_word", 64'(got_wr[i]), 64'(wdat[i]));
    for (int i = 0; i < v.e_rd && i < got_rd.size(); i++) chk("rd_word", 64'(got_rd[i]), 64'(wdat[i]));
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  vec_t tbl[10];
  vec_t v;
  int xfer;

  initial begin
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_err", 64'({done, err, wr_ready, rd_valid}), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_instr", 64'(cpu_recv_instr), 64'd0);
    chk("rst_in_data", 64'(cpu_in_data), 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    //          op addr      cnt gap dly nz na base     dn er in len wr rd rel
    tbl[0] = '{1, 32'h100,  3,  0,  2, 0, 0, 32'hA,    1, 0, 1, 3, 3, 0, 12};
    tbl[1] = '{2, 32'h200,  2,  0,  1, 1, 0, 32'h5000, 1, 0, 1, 2, 0, 2, 7};
    tbl[2] = '{3, 32'h40,   7,  0, 50, 0, 0, 32'h0,    1, 0, 1, 0, 0, 0, 54};
    tbl[3] = '{0, 32'h55,   4,  0,  0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 1};
    tbl[4] = '{1, 32'h600,  0,  0,  0, 1, 0, 32'h0,    1, 0, 1, 0, 0, 0, 3};
    tbl[5] = '{2, 32'h700,  0,  0,  0, 1, 0, 32'h0,    1, 0, 1, 0, 0, 0, 3};
    tbl[6] = '{1, 32'h300,  2, 100, 0, 1, 0, 32'hC0,   1, 0, 1, 2, 2, 0, 205};
    tbl[7] = '{2, 32'h800,  1,  0, 59, 0, 0, 32'hBEE,  1, 0, 1, 1, 0, 1, 63};
    tbl[8] = '{2, 32'h900,  1,  0,  0, 0, 1, 32'h0,    0, 1, 1, 1, 0, 0, 63};
    tbl[9] = '{3, 32'hA00,  0,  0,  0, 0, 1, 32'h0,    0, 1, 1, 0, 0, 0, 63};

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 64; i++) begin
        gap[i] = tbl[r].gap; dly[i] = tbl[r].dly; wdat[i] = tbl[r].base + 32'(i);
      end
      run_case(tbl[r]);
    end

    // Read stream order with specific card words
    wdat[0] = 32'hDEADBEEF; wdat[1] = 32'h12345678;
    gap[0] = 0; gap[1] = 0; dly[0] = 1; dly[1] = 3;
    v = '{2, 32'h1234, 2, 0, 0, 0, 0, 32'h0, 1, 0, 1, 2, 0, 2, 3 + 2 + 4};
    run_case(v);

    // Reset during a write copy after two accepted beats
    txn_id++;
    acc = cyc;
    req_valid = 1'b1; req_op = 2'd1; req_addr = 32'h500; req_count = 16'd4;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 32'h70 + 32'(i);
      tick();
      cpu_out_ack = 1'b1;
      tick();
      cpu_out_ack = 1'b0;
    end
    wr_valid = 1'b1; wr_data = 32'h72;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pulses", 64'({done, err, wr_ready, rd_valid}), 64'd0);
    chk("mid_rst_instr", 64'(cpu_recv_instr), 64'd0);
    chk("mid_rst_in_data", 64'(cpu_in_data), 64'd0);
    wr_valid = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("mid_rst_beats", 64'(got_wr.size()), 64'd2);
    chk("mid_rst_no_done", 64'(done_cnt + err_cnt), 64'd0);
    chk("mid_rst_idle", 64'(req_ready), 64'd1);

    // Randomized requests; expected latency and streams follow from the protocol rules
    for (int t = 0; t < 30; t++) begin
      v.op = $urandom_range(0, 3);
      v.addr = $urandom;
      v.count = $urandom_range(0, 6);
      v.noisy = 1; v.no_ack = 0; v.gap = 0; v.dly = 0; v.base = '0;
      for (int i = 0; i < 64; i++) begin
        gap[i] = $urandom_range(0, 4); dly[i] = $urandom_range(0, 12); wdat[i] = $urandom;
      end
      xfer = 0;
      if (v.op == 3) xfer = dly[0] + 1;
      else for (int i = 0; i < v.count; i++) xfer += ((v.op == 1) ? gap[i] : 0) + dly[i] + 1;
      v.e_done  = (v.op != 0) ? 1 : 0;
      v.e_err   = (v.op == 0) ? 1 : 0;
      v.e_instr = (v.op != 0) ? 1 : 0;
      v.e_len   = (v.op == 3) ? 0 : v.count;
      v.e_wr    = (v.op == 1) ? v.count : 0;
      v.e_rd    = (v.op == 2) ? v.count : 0;
      v.e_rel   = (v.op == 0) ? 1 : 3 + xfer;
      run_case(v);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
